// File: rtl/itrx_aib_phy_io_buf_cfg_seq.sv
// Per-pad IO buffer configuration sequencer.
// Accepts a pad mode over valid/ready and steps the buffer through
// quiesce -> apply code -> release analog reset -> release RX data reset,
// so the decode logic never sees a mixed old/new configuration.
module itrx_aib_phy_io_buf_cfg_seq #(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_vld,
    input  logic [2:0] cfg_mode,
    output logic       cfg_rdy,
    input  logic       pad_fail,
    output logic       txen,
    output logic [2:0] rxen,
    output logic       iredrstb,
    output logic       rx_irstb,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [2:0] cur_mode
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [2:0]       RX_NRX = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_APPLY,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t           r_state, w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_mode;     // holding register for the accepted mode
    logic             r_seen;     // a sequence has completed since reset
    logic             r_rdy, r_txen, r_ired, r_rxi, r_done, r_err;
    logic [2:0]       r_rxen, r_cur;

    logic             w_last, w_timed, w_acc;
    logic             w_txen, w_ired, w_rxi, w_rdy, w_done, w_err;
    logic [2:0]       w_rxen;
    logic [3:0]       w_code;

    // {txen, rxen} for a pad mode; reserved mode 7 falls back to OFF
    function automatic logic [3:0] enc(input logic [2:0] m);
        logic [3:0] c;
        case (m)
            3'd1:    c = {1'b1, 3'b010};
            3'd2:    c = {1'b0, 3'b000};
            3'd3:    c = {1'b0, 3'b100};
            3'd4:    c = {1'b0, 3'b001};
            3'd5:    c = {1'b0, 3'b011};
            3'd6:    c = {1'b1, 3'b000};
            default: c = {1'b0, 3'b010};
        endcase
        return c;
    endfunction

    assign w_last  = (r_cnt == LAST);
    assign w_timed = (r_state == ST_QUIESCE) || (r_state == ST_APPLY) ||
                     (r_state == ST_RELEASE);
    assign w_acc   = cfg_vld && r_rdy;
    assign w_code  = enc(r_mode);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt;
    end

    // Next state, and the output values that state will present next cycle
    always_comb begin
        w_nxt  = r_state;
        w_txen = 1'b0;
        w_rxen = RX_NRX;
        w_ired = 1'b0;
        w_rxi  = 1'b0;
        w_rdy  = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE:    if (w_acc)  w_nxt = ST_QUIESCE;
            ST_QUIESCE: if (w_last) w_nxt = ST_APPLY;
            ST_APPLY:   if (w_last) w_nxt = ST_RELEASE;
            ST_RELEASE: if (w_last) w_nxt = ST_DONE;
            ST_DONE:                w_nxt = ST_IDLE;
            default:                w_nxt = ST_IDLE;
        endcase
        case (w_nxt)
            ST_IDLE: begin
                // before the first completed sequence this is the reset code
                {w_txen, w_rxen} = w_code;
                w_ired = r_seen;
                w_rxi  = r_seen;
                w_rdy  = 1'b1;
            end
            ST_APPLY: begin
                {w_txen, w_rxen} = w_code;
            end
            ST_RELEASE: begin
                {w_txen, w_rxen} = w_code;
                w_ired = 1'b1;
            end
            ST_DONE: begin
                {w_txen, w_rxen} = w_code;
                w_ired = 1'b1;
                w_rxi  = 1'b1;
                w_done = 1'b1;
                w_err  = (r_mode == 3'd7);
            end
            default: ;
        endcase
        // broken pad: keep both resets asserted while the sequence runs on
        if (pad_fail) begin
            w_ired = 1'b0;
            w_rxi  = 1'b0;
        end
    end

    // Phase counter: runs only in timed phases, clears on every state change
    always_ff @(posedge clk) begin
        if (rst)                  r_cnt <= '0;
        else if (w_nxt != r_state) r_cnt <= '0;
        else if (w_timed)          r_cnt <= r_cnt + 1'b1;
    end

    // Mode capture on acceptance, applied-mode and completion tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 3'd0;
            r_cur  <= 3'd0;
            r_seen <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_acc) r_mode <= cfg_mode;
            if (w_nxt == ST_DONE) begin
                r_cur  <= r_mode;
                r_seen <= 1'b1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txen <= 1'b0;
            r_rxen <= RX_NRX;
            r_ired <= 1'b0;
            r_rxi  <= 1'b0;
            r_rdy  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_txen <= w_txen;
            r_rxen <= w_rxen;
            r_ired <= w_ired;
            r_rxi  <= w_rxi;
            r_rdy  <= w_rdy;
            r_done <= w_done;
            r_err  <= w_err;
        end
    end

    assign txen     = r_txen;
    assign rxen     = r_rxen;
    assign iredrstb = r_ired;
    assign rx_irstb = r_rxi;
    assign cfg_rdy  = r_rdy;
    assign cfg_done = r_done;
    assign cfg_err  = r_err;
    assign cur_mode = r_cur;

endmodule

// File: tb/tb_itrx_aib_phy_io_buf_cfg_seq.sv
// Directed bench for the pad configuration sequencer (S=4 and S=1 builds).
module tb_itrx_aib_phy_io_buf_cfg_seq;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst, cfg_vld, pad_fail, cfg_rdy, txen, iredrstb, rx_irstb, cfg_done, cfg_err;
    logic [2:0] cfg_mode, rxen, cur_mode;
    logic       vld1, rdy1, txen1, ired1, rxi1, done1, err1;
    logic [2:0] mode1, rxen1, cur1;

    int         total = 0;
    int         bad   = 0;
    logic [2:0] prev_mode;

    always #5 clk = ~clk;

    itrx_aib_phy_io_buf_cfg_seq #(.SETTLE_CYC(S), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_mode(cfg_mode), .cfg_rdy(cfg_rdy),
        .pad_fail(pad_fail), .txen(txen), .rxen(rxen), .iredrstb(iredrstb),
        .rx_irstb(rx_irstb), .cfg_done(cfg_done), .cfg_err(cfg_err), .cur_mode(cur_mode)
    );

    itrx_aib_phy_io_buf_cfg_seq #(.SETTLE_CYC(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .cfg_vld(vld1), .cfg_mode(mode1), .cfg_rdy(rdy1),
        .pad_fail(1'b0), .txen(txen1), .rxen(rxen1), .iredrstb(ired1),
        .rx_irstb(rxi1), .cfg_done(done1), .cfg_err(err1), .cur_mode(cur1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full S=4 sequence; ends in cycle 3S+2 with cfg_rdy expected high.
    // chain: keep cfg_vld high with mode nm right after acceptance.
    // pf: cycle in which pad_fail is pulsed (0 = none).
    task automatic run_seq(input logic [2:0] m, input logic etx, input logic [2:0] erx,
                           input logic chain, input logic [2:0] nm, input int pf);
        logic       x_tx, x_ired, x_rxi, x_done, x_err, x_rdy;
        logic [2:0] x_rx, x_cur;
        cfg_vld  = 1'b1;
        cfg_mode = m;
        chk($sformatf("rdy_pre_m%0d", m), 32'(cfg_rdy), 32'(1'b1));
        step();
        if (chain) cfg_mode = nm;
        else       cfg_vld  = 1'b0;
        for (int c = 1; c <= 3*S+2; c++) begin
            pad_fail = (pf != 0 && c == pf);
            x_done = 1'b0; x_err = 1'b0; x_rdy = 1'b0;
            if (c <= S) begin
                x_tx = 1'b0; x_rx = 3'b010; x_ired = 1'b0; x_rxi = 1'b0;
            end else if (c <= 2*S) begin
                x_tx = etx; x_rx = erx; x_ired = 1'b0; x_rxi = 1'b0;
            end else if (c <= 3*S) begin
                x_tx = etx; x_rx = erx; x_ired = 1'b1; x_rxi = 1'b0;
            end else begin
                x_tx = etx; x_rx = erx; x_ired = 1'b1; x_rxi = 1'b1;
                x_done = (c == 3*S+1);
                x_err  = (c == 3*S+1) && (m == 3'd7);
                x_rdy  = (c == 3*S+2);
            end
            if (pf != 0 && c == pf+1) begin
                x_ired = 1'b0; x_rxi = 1'b0;
            end
            x_cur = (c >= 3*S+1) ? m : prev_mode;
            chk($sformatf("txen_m%0d_c%0d", m, c),  32'(txen),     32'(x_tx));
            chk($sformatf("rxen_m%0d_c%0d", m, c),  32'(rxen),     32'(x_rx));
            chk($sformatf("ired_m%0d_c%0d", m, c),  32'(iredrstb), 32'(x_ired));
            chk($sformatf("rxi_m%0d_c%0d", m, c),   32'(rx_irstb), 32'(x_rxi));
            chk($sformatf("done_m%0d_c%0d", m, c),  32'(cfg_done), 32'(x_done));
            chk($sformatf("err_m%0d_c%0d", m, c),   32'(cfg_err),  32'(x_err));
            chk($sformatf("rdy_m%0d_c%0d", m, c),   32'(cfg_rdy),  32'(x_rdy));
            chk($sformatf("cur_m%0d_c%0d", m, c),   32'(cur_mode), 32'(x_cur));
            if (c < 3*S+2) step();
        end
        pad_fail  = 1'b0;
        prev_mode = m;
    endtask

    initial begin
        rst = 1'b1; cfg_vld = 1'b0; cfg_mode = 3'd0; pad_fail = 1'b0;
        vld1 = 1'b0; mode1 = 3'd0; prev_mode = 3'd0;
        step(); step();

        // reset values
        chk("rst_txen", 32'(txen), 32'(1'b0));
        chk("rst_rxen", 32'(rxen), 32'(3'b010));
        chk("rst_ired", 32'(iredrstb), 32'(1'b0));
        chk("rst_rxi",  32'(rx_irstb), 32'(1'b0));
        chk("rst_rdy",  32'(cfg_rdy), 32'(1'b0));
        chk("rst_done", 32'(cfg_done), 32'(1'b0));
        chk("rst_err",  32'(cfg_err), 32'(1'b0));
        chk("rst_cur",  32'(cur_mode), 32'(3'd0));

        // first cycle after reset: ready, still holding reset code
        rst = 1'b0;
        step();
        chk("post_rst_rdy",  32'(cfg_rdy), 32'(1'b1));
        chk("post_rst_ired", 32'(iredrstb), 32'(1'b0));
        chk("post_rst_rxi",  32'(rx_irstb), 32'(1'b0));
        chk("post_rst_rxen", 32'(rxen), 32'(3'b010));
        chk("post_rst_rdy1", 32'(rdy1), 32'(1'b1));

        // RX_DDR
        run_seq(3'd4, 1'b0, 3'b001, 1'b0, 3'd0, 0);
        // TX then RX_CKI back to back with cfg_vld held
        run_seq(3'd1, 1'b1, 3'b010, 1'b1, 3'd5, 0);
        run_seq(3'd5, 1'b0, 3'b011, 1'b0, 3'd0, 0);
        // reserved mode
        run_seq(3'd7, 1'b0, 3'b010, 1'b0, 3'd0, 0);
        // RX_SDR with pad_fail pulse in cycle 10
        run_seq(3'd3, 1'b0, 3'b100, 1'b0, 3'd0, 10);
        // TXRX_ASI
        run_seq(3'd6, 1'b1, 3'b000, 1'b0, 3'd0, 0);

        // reset in cycle 6 of a TX sequence
        cfg_vld = 1'b1; cfg_mode = 3'd1;
        step();
        cfg_vld = 1'b0;
        for (int c = 2; c <= 6; c++) step();
        rst = 1'b1;
        step();
        chk("mid_rst_txen", 32'(txen), 32'(1'b0));
        chk("mid_rst_rxen", 32'(rxen), 32'(3'b010));
        chk("mid_rst_ired", 32'(iredrstb), 32'(1'b0));
        chk("mid_rst_rxi",  32'(rx_irstb), 32'(1'b0));
        chk("mid_rst_rdy",  32'(cfg_rdy), 32'(1'b0));
        chk("mid_rst_done", 32'(cfg_done), 32'(1'b0));
        chk("mid_rst_cur",  32'(cur_mode), 32'(3'd0));
        rst = 1'b0;
        step();
        chk("mid_rel_rdy",  32'(cfg_rdy), 32'(1'b1));
        chk("mid_rel_done", 32'(cfg_done), 32'(1'b0));
        chk("mid_rel_ired", 32'(iredrstb), 32'(1'b0));
        chk("mid_rel_txen", 32'(txen), 32'(1'b0));
        prev_mode = 3'd0;

        // S=1 build, RX_ASI
        vld1 = 1'b1; mode1 = 3'd2;
        chk("s1_rdy_pre", 32'(rdy1), 32'(1'b1));
        step();
        vld1 = 1'b0;
        chk("s1_c1_rxen", 32'(rxen1), 32'(3'b010));
        chk("s1_c1_ired", 32'(ired1), 32'(1'b0));
        step();
        chk("s1_c2_rxen", 32'(rxen1), 32'(3'b000));
        chk("s1_c2_ired", 32'(ired1), 32'(1'b0));
        step();
        chk("s1_c3_ired", 32'(ired1), 32'(1'b1));
        chk("s1_c3_rxi",  32'(rxi1), 32'(1'b0));
        chk("s1_c3_done", 32'(done1), 32'(1'b0));
        step();
        chk("s1_c4_done", 32'(done1), 32'(1'b1));
        chk("s1_c4_rxi",  32'(rxi1), 32'(1'b1));
        chk("s1_c4_cur",  32'(cur1), 32'(3'd2));
        chk("s1_c4_rdy",  32'(rdy1), 32'(1'b0));
        chk("s1_c4_err",  32'(err1), 32'(1'b0));
        chk("s1_c4_txen", 32'(txen1), 32'(1'b0));
        step();
        chk("s1_c5_rdy",  32'(rdy1), 32'(1'b1));
        chk("s1_c5_done", 32'(done1), 32'(1'b0));
        chk("s1_c5_rxen", 32'(rxen1), 32'(3'b000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
